// File: rtl/crc5_append_stage_if.sv
// Handshake bundle for crc5_append_stage.
// Upstream side: DATA_UP / VALID_UP / READY_UP (payload words from the receive FIFO).
// Downstream side: DATA_DOWN / VALID_DOWN / READY_DOWN ({payload, crc5} to the consumer).
// Status: BUSY (CRC in progress), WORD_CNT (words delivered downstream).
// slave modport is the stage itself; master modport is whatever drives and observes it.
interface crc5_append_stage_if #(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned CNT_WIDTH = 16
);
  logic [WIDTH-1:0]     DATA_UP;
  logic                 VALID_UP;
  logic                 READY_UP;
  logic [WIDTH+4:0]     DATA_DOWN;
  logic                 VALID_DOWN;
  logic                 READY_DOWN;
  logic                 BUSY;
  logic [CNT_WIDTH-1:0] WORD_CNT;

  modport slave (
    input  DATA_UP, VALID_UP, READY_DOWN,
    output READY_UP, DATA_DOWN, VALID_DOWN, BUSY, WORD_CNT
  );

  modport master (
    output DATA_UP, VALID_UP, READY_DOWN,
    input  READY_UP, DATA_DOWN, VALID_DOWN, BUSY, WORD_CNT
  );
endinterface

// File: rtl/crc5_append_stage.sv
// Appends a USB-style CRC5 (x^5+x^2+1, init 5'h1F, inverted output) to each payload word.
// The CRC is computed bit-serially, MSB first, one bit per clock.
// Ports:
//   CLK    - clock, rising edge
//   RESET  - asynchronous reset, active high
//   bus_io - handshake bundle (slave side): DATA_UP/VALID_UP/READY_UP in,
//            DATA_DOWN/VALID_DOWN/READY_DOWN out, BUSY and WORD_CNT status.
module crc5_append_stage #(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  crc5_append_stage_if.slave     bus_io
);

  localparam int unsigned BitW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BitW-1:0] LastBit = BitW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StOut} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     payload_q;
  logic [WIDTH-1:0]     shift_q;
  logic [4:0]           crc_q;
  logic [BitW-1:0]      bit_cnt_q;
  logic [WIDTH+4:0]     data_down_q;
  logic                 valid_down_q;
  logic [CNT_WIDTH-1:0] word_cnt_q;

  logic       ready_up;
  logic       busy;
  logic       accept;
  logic       down_hs;
  logic       last_bit;
  logic       fb;
  logic [4:0] crc_step;

  assign accept   = bus_io.VALID_UP && ready_up;
  assign down_hs  = (state_q == StOut) && valid_down_q && bus_io.READY_DOWN;
  assign last_bit = (bit_cnt_q == LastBit);

  // One serial CRC step on the current shift-register MSB.
  assign fb       = shift_q[WIDTH-1] ^ crc_q[4];
  assign crc_step = {crc_q[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StCalc;
      StCalc: if (last_bit) state_d = StOut;
      StOut: begin
        // A new word accepted during the downstream handshake skips IDLE.
        if (down_hs) state_d = bus_io.VALID_UP ? StCalc : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic; READY_UP follows READY_DOWN in OUT so words can flow back-to-back.
  always_comb begin
    ready_up = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      StIdle:  ready_up = 1'b1;
      StCalc:  busy     = 1'b1;
      StOut:   ready_up = bus_io.READY_DOWN;
      default: ready_up = 1'b0;
    endcase
  end

  // Datapath
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      payload_q    <= '0;
      shift_q      <= '0;
      crc_q        <= 5'h1F;
      bit_cnt_q    <= '0;
      data_down_q  <= '0;
      valid_down_q <= 1'b0;
      word_cnt_q   <= '0;
    end else begin
      if (down_hs) begin
        valid_down_q <= 1'b0;
        word_cnt_q   <= word_cnt_q + 1'b1;
      end
      if (accept) begin
        payload_q <= bus_io.DATA_UP;
        shift_q   <= bus_io.DATA_UP;
        crc_q     <= 5'h1F;
        bit_cnt_q <= '0;
      end else if (state_q == StCalc) begin
        shift_q   <= shift_q << 1;
        crc_q     <= crc_step;
        bit_cnt_q <= bit_cnt_q + 1'b1;
        if (last_bit) begin
          data_down_q  <= {payload_q, ~crc_step};
          valid_down_q <= 1'b1;
        end
      end
    end
  end

  assign bus_io.READY_UP   = ready_up;
  assign bus_io.BUSY       = busy;
  assign bus_io.DATA_DOWN  = data_down_q;
  assign bus_io.VALID_DOWN = valid_down_q;
  assign bus_io.WORD_CNT   = word_cnt_q;

endmodule

// File: tb/tb_crc5_append_stage.sv
// Directed bench for crc5_append_stage: scoreboard of expected {payload, crc5} words,
// plus a second instance with a 4-bit counter fed the same stimulus for the wrap check.
module tb_crc5_append_stage;

  localparam int unsigned WIDTH     = 10;
  localparam int unsigned CNT_WIDTH = 16;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  crc5_append_stage_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) if_m ();
  crc5_append_stage_if #(.WIDTH(WIDTH), .CNT_WIDTH(4))         if_w ();

  assign if_w.DATA_UP    = if_m.DATA_UP;
  assign if_w.VALID_UP   = if_m.VALID_UP;
  assign if_w.READY_DOWN = if_m.READY_DOWN;

  crc5_append_stage #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .bus_io (if_m)
  );

  crc5_append_stage #(.WIDTH(WIDTH), .CNT_WIDTH(4)) u_dut_w (
    .CLK    (CLK),
    .RESET  (RESET),
    .bus_io (if_w)
  );

  int checks = 0;
  int errors = 0;
  logic [WIDTH+4:0] exp_q[$];
  logic [WIDTH+4:0] mon_exp;
  time last_accept_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] crc5_ref(input logic [WIDTH-1:0] d);
    logic [4:0] c;
    logic       f;
    c = 5'h1F;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      f = d[i] ^ c[4];
      c = {c[3:0], 1'b0};
      if (f) c = c ^ 5'h05;
    end
    return ~c;
  endfunction

  // Present a word, wait for acceptance, record its expected output.
  task automatic send_word(input logic [WIDTH-1:0] d);
    int n;
    n = 0;
    if_m.DATA_UP  = d;
    if_m.VALID_UP = 1'b1;
    do begin
      @(negedge CLK);
      n++;
    end while (!if_m.READY_UP && n < 100);
    if (!if_m.READY_UP) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout: observed READY_UP=0 expected READY_UP=1");
    end else begin
      exp_q.push_back({d, crc5_ref(d)});
      @(posedge CLK);
      last_accept_t = $time;
    end
    #1;
    if_m.VALID_UP = 1'b0;
  endtask

  // Count rising edges until VALID_DOWN is seen.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge CLK);
      #1;
      n++;
    end while (!if_m.VALID_DOWN && n < 100);
    if (!if_m.VALID_DOWN) begin
      checks++;
      errors++;
      $error("FAIL valid_timeout: observed VALID_DOWN=0 expected VALID_DOWN=1");
    end
  endtask

  // Scoreboard: pop on every downstream handshake.
  always @(negedge CLK) begin
    if (RESET === 1'b0 && if_m.VALID_DOWN && if_m.READY_DOWN) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_output: observed %0h expected none", if_m.DATA_DOWN);
      end else begin
        mon_exp = exp_q.pop_front();
        check("data_down", 32'(if_m.DATA_DOWN), 32'(mon_exp));
        check("narrow_data_down", 32'(if_w.DATA_DOWN), 32'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    time t_prev;
    logic [WIDTH+4:0] bp_exp;

    RESET           = 1'b1;
    if_m.DATA_UP    = '0;
    if_m.VALID_UP   = 1'b0;
    if_m.READY_DOWN = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ready_up", 32'(if_m.READY_UP), 32'd1);
    check("rst_valid_down", 32'(if_m.VALID_DOWN), 32'd0);
    check("rst_busy", 32'(if_m.BUSY), 32'd0);
    check("rst_data_down", 32'(if_m.DATA_DOWN), 32'd0);
    check("rst_word_cnt", 32'(if_m.WORD_CNT), 32'd0);
    RESET = 1'b0;

    // Single word 0x000
    send_word(10'h000);
    wait_valid(n);
    check("latency", 32'(n), 32'd10);
    check("zero_word", 32'(if_m.DATA_DOWN), 32'h0006);
    @(posedge CLK);
    #1;
    check("zero_cnt", 32'(if_m.WORD_CNT), 32'd1);
    check("zero_idle_ready", 32'(if_m.READY_UP), 32'd1);
    check("zero_idle_busy", 32'(if_m.BUSY), 32'd0);
    check("zero_valid_drop", 32'(if_m.VALID_DOWN), 32'd0);

    // Reset in the middle of CALC discards the in-flight word
    send_word(10'h3FF);
    repeat (3) @(posedge CLK);
    #1;
    check("mid_busy", 32'(if_m.BUSY), 32'd1);
    RESET = 1'b1;
    #1;
    check("mid_rst_ready_up", 32'(if_m.READY_UP), 32'd1);
    check("mid_rst_valid_down", 32'(if_m.VALID_DOWN), 32'd0);
    check("mid_rst_busy", 32'(if_m.BUSY), 32'd0);
    check("mid_rst_data_down", 32'(if_m.DATA_DOWN), 32'd0);
    check("mid_rst_word_cnt", 32'(if_m.WORD_CNT), 32'd0);
    check("mid_rst_narrow_cnt", 32'(if_w.WORD_CNT), 32'd0);
    exp_q.delete();
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    repeat (15) @(posedge CLK);
    #1;
    check("discarded_no_valid", 32'(if_m.VALID_DOWN), 32'd0);

    // Single word 0x3FF
    send_word(10'h3FF);
    wait_valid(n);
    check("ones_word", 32'(if_m.DATA_DOWN), 32'h7FF3);
    @(posedge CLK);
    #1;
    check("ones_cnt", 32'(if_m.WORD_CNT), 32'd1);

    // Backpressure: hold READY_DOWN low for 20 cycles in OUT
    if_m.READY_DOWN = 1'b0;
    send_word(10'h2A5);
    bp_exp = {10'h2A5, crc5_ref(10'h2A5)};
    wait_valid(n);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check("bp_data_stable", 32'(if_m.DATA_DOWN), 32'(bp_exp));
      check("bp_valid", 32'(if_m.VALID_DOWN), 32'd1);
      check("bp_ready_up", 32'(if_m.READY_UP), 32'd0);
      check("bp_cnt", 32'(if_m.WORD_CNT), 32'd1);
    end
    @(posedge CLK);
    #1;
    if_m.READY_DOWN = 1'b1;
    @(posedge CLK);
    #1;
    check("bp_release_valid", 32'(if_m.VALID_DOWN), 32'd0);
    check("bp_release_cnt", 32'(if_m.WORD_CNT), 32'd2);
    repeat (3) @(posedge CLK);
    #1;
    check("bp_once_cnt", 32'(if_m.WORD_CNT), 32'd2);

    // Back-to-back stream of 8 random words: one accept every 11 cycles
    t_prev = 0;
    for (int i = 0; i < 8; i++) begin
      send_word(WIDTH'($urandom));
      if (i > 0) check("b2b_period", 32'(last_accept_t - t_prev), 32'd110);
      t_prev = last_accept_t;
    end
    wait_valid(n);
    @(posedge CLK);
    #1;
    check("b2b_cnt", 32'(if_m.WORD_CNT), 32'd10);

    // Seven more words: 17 since reset, 4-bit counter wraps to 1
    for (int i = 0; i < 7; i++) begin
      send_word(WIDTH'($urandom));
    end
    wait_valid(n);
    @(posedge CLK);
    #1;
    check("total_cnt", 32'(if_m.WORD_CNT), 32'd17);
    check("wrap_cnt", 32'(if_w.WORD_CNT), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc5_append_stage.md
Name: crc5_append_stage

Overview:
- Downstream neighbour of the receive FIFO. Consumes WIDTH-bit payload words over a valid/ready handshake.
- Computes a USB-style CRC5 over each word, one bit per cycle, MSB first.
- Emits {payload, crc5} downstream over a second valid/ready handshake.
- Keeps a count of completed words for scoreboard cross-checking.

Parameters:
- WIDTH, 10, payload bits per word. Must be ≥2.
- CNT_WIDTH, 16, width of the completed-word counter.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RESET  input  1  asynchronous reset, active-high.
- DATA_UP  input  WIDTH  payload word from the FIFO.
- VALID_UP  input  1  payload word valid.
- READY_UP  output  1  block can accept a word.
- DATA_DOWN  output  WIDTH+5  {payload[WIDTH-1:0], crc5[4:0]}.
- VALID_DOWN  output  1  DATA_DOWN valid.
- READY_DOWN  input  1  consumer accepts DATA_DOWN.
- BUSY  output  1  high while in CALC.
- WORD_CNT  output  CNT_WIDTH  number of words delivered downstream.

Behaviour:
- Reset (RESET=1, asynchronous): state=IDLE, READY_UP=1, VALID_DOWN=0, BUSY=0, DATA_DOWN=0, WORD_CNT=0, bit counter=0.
- CRC5 polynomial and per-bit update:
  - Polynomial x^5+x^2+1. Init value 5'b11111.
  - Per input bit d: fb = d ^ crc[4]; crc_next = {crc[3:0],1'b0} ^ (fb ? 5'b00101 : 5'b00000).
  - Output crc5 = ~crc after all WIDTH bits.
- State IDLE:
  - READY_UP=1.
  - On VALID_UP&&READY_UP: latch DATA_UP into the payload and shift registers, set crc=5'b11111, bit counter=0, go to CALC.
- State CALC:
  - READY_UP=0, BUSY=1.
  - Each cycle: consume the shift-register MSB, shift left, increment the bit counter.
  - After the WIDTH-th bit is processed: register DATA_DOWN={payload, ~crc_next}, set VALID_DOWN=1, go to OUT.
  - Latency: VALID_DOWN is first seen high WIDTH cycles after the accepting edge (10 cycles at default).
- State OUT:
  - VALID_DOWN=1. DATA_DOWN is held stable until the handshake.
  - READY_UP = READY_DOWN (combinational) to allow back-to-back operation.
  - On VALID_DOWN&&READY_DOWN: increment WORD_CNT (wraps modulo 2^CNT_WIDTH).
    - If VALID_UP is also high that cycle: accept the new word and go directly to CALC (VALID_DOWN drops next cycle).
    - Otherwise: go to IDLE.
  - READY_DOWN low: stay in OUT indefinitely. No data change, no upstream accept.
- Throughput: one word per WIDTH+1 cycles maximum.
- VALID_UP while in CALC is ignored (READY_UP=0). The upstream FIFO holds the word.
- Reset asserted mid-CALC or in OUT: the in-flight word is discarded, all outputs return to reset values immediately, and WORD_CNT is cleared.
- DATA_DOWN and VALID_DOWN are register outputs. READY_UP is combinational only in OUT.

Test Plan:
- Reset then idle -> READY_UP=1, VALID_DOWN=0, WORD_CNT=0, DATA_DOWN=0. Asserting RESET mid-CALC returns all outputs to these values within the same cycle.
- Single word DATA_UP=10'h000 -> after 10 cycles VALID_DOWN=1, DATA_DOWN=15'h0006 (crc5=5'h06). With READY_DOWN=1, WORD_CNT becomes 1 and the state returns to IDLE.
- Single word DATA_UP=10'h3FF -> DATA_DOWN={10'h3FF,5'h13}=15'h7FF3.
- Backpressure: hold READY_DOWN=0 for 20 cycles in OUT -> DATA_DOWN stable, READY_UP=0, WORD_CNT unchanged. Releasing READY_DOWN completes the handshake exactly once.
- Back-to-back stream of 8 random words with READY_DOWN=1 and VALID_UP=1 -> new word accepted in the same cycle as the downstream handshake, one output per 11 cycles. CRCs match the bit-serial reference model and WORD_CNT=8.
- Counter wrap with CNT_WIDTH=4: deliver 17 words -> WORD_CNT=1.
